// File: rtl/pipe_ctrl_pkg.sv
// Shared constants and state encoding for the pipeline hazard controller.
package pipe_ctrl_pkg;

  localparam int unsigned CTRL_RD_MEM = 0;
  localparam int unsigned CTRL_WR_MEM = 1;
  localparam int unsigned CTRL_BYTE   = 2;
  localparam int unsigned CTRL_WR_REG = 3;
  localparam int unsigned CTRL_BR     = 4;
  localparam int unsigned CTRL_LD     = 5;
  localparam int unsigned CTRL_MUL    = 6;
  localparam int unsigned CTRL_W      = 7;

  localparam int unsigned REG_IDX_W   = 5;

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MUL_WAIT = 1'b1
  } state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with enable and synchronous active-high reset.
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  output logic [W-1:0] count
);

  logic [W-1:0] r_count;

  // Count enabled cycles, holding at all-ones once reached.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (en && (r_count != '1)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count = r_count;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller: mem-wait freeze, multi-cycle mul interlock,
// taken-branch flush, load-use bubble, and a stall-cycle counter.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MUL_LAT = 4,
  parameter int unsigned CNT_W   = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [REG_IDX_W-1:0] id_rgS1_index,
  input  logic [REG_IDX_W-1:0] id_rgS2_index,
  input  logic                 id_use_s1,
  input  logic                 id_use_s2,
  input  logic [CTRL_W-1:0]    ex_control,
  input  logic [REG_IDX_W-1:0] ex_rgD_index,
  input  logic                 ex_br_taken,
  input  logic                 mem_stall,
  output logic                 pc_we,
  output logic                 if_id_we,
  output logic                 if_id_flush,
  output logic                 id_ex_we,
  output logic                 id_ex_flush,
  output logic                 ex_mem_we,
  output logic                 ex_mem_flush,
  output logic                 mul_busy,
  output logic [CNT_W-1:0]     stall_cycles
);

  // Remaining freeze cycles after the mul-start cycle; the final MUL_WAIT
  // cycle (count zero) is the release cycle, so MUL_LAT cycles total.
  localparam logic [3:0] MUL_INIT = (MUL_LAT > 1) ? 4'(MUL_LAT - 2) : 4'd0;
  localparam logic       MUL_STALLS = (MUL_LAT > 1);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [3:0] r_mul_cnt;
  logic [3:0] w_mul_cnt_nxt;
  logic       w_load_use;
  logic       w_stall_en;
  logic       w_unused_ctrl;

  // Only load and mul bits of the ID/EX bundle matter here.
  assign w_unused_ctrl = &{1'b0, ex_control[CTRL_BR:CTRL_RD_MEM]};

  // Load in EX whose destination is a live source of the ID instruction.
  always_comb begin
    w_load_use = 1'b0;
    if (ex_control[CTRL_LD] && (ex_rgD_index != '0)) begin
      w_load_use = (id_use_s1 && (id_rgS1_index == ex_rgD_index)) ||
                   (id_use_s2 && (id_rgS2_index == ex_rgD_index));
    end
  end

  // Prioritised pipeline-control decode and next-state logic.
  always_comb begin
    pc_we         = 1'b1;
    if_id_we      = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_we      = 1'b1;
    id_ex_flush   = 1'b0;
    ex_mem_we     = 1'b1;
    ex_mem_flush  = 1'b0;
    w_state_nxt   = r_state;
    w_mul_cnt_nxt = r_mul_cnt;

    if (reset) begin
      w_state_nxt   = RUN;
      w_mul_cnt_nxt = '0;
    end else if (mem_stall) begin
      pc_we     = 1'b0;
      if_id_we  = 1'b0;
      id_ex_we  = 1'b0;
      ex_mem_we = 1'b0;
    end else if (r_state == MUL_WAIT) begin
      if (r_mul_cnt != '0) begin
        pc_we         = 1'b0;
        if_id_we      = 1'b0;
        id_ex_we      = 1'b0;
        ex_mem_flush  = 1'b1;
        w_mul_cnt_nxt = r_mul_cnt - 1'b1;
      end else begin
        w_state_nxt = RUN;
      end
    end else if (ex_control[CTRL_MUL] && MUL_STALLS) begin
      pc_we         = 1'b0;
      if_id_we      = 1'b0;
      id_ex_we      = 1'b0;
      ex_mem_flush  = 1'b1;
      w_state_nxt   = MUL_WAIT;
      w_mul_cnt_nxt = MUL_INIT;
    end else if (ex_br_taken) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (w_load_use) begin
      pc_we       = 1'b0;
      if_id_we    = 1'b0;
      id_ex_flush = 1'b1;
    end
  end

  // State and mul countdown registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= RUN;
      r_mul_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_mul_cnt <= w_mul_cnt_nxt;
    end
  end

  assign mul_busy   = (r_state == MUL_WAIT);
  assign w_stall_en = !reset && !pc_we;

  sat_counter #(
    .W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (w_stall_en),
    .count (stall_cycles)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl (MUL_LAT=4).
module tb_pipeline_hazard_ctrl;

  logic        clk;
  logic        reset;
  logic [4:0]  id_rgS1_index;
  logic [4:0]  id_rgS2_index;
  logic        id_use_s1;
  logic        id_use_s2;
  logic [6:0]  ex_control;
  logic [4:0]  ex_rgD_index;
  logic        ex_br_taken;
  logic        mem_stall;
  logic        pc_we;
  logic        if_id_we;
  logic        if_id_flush;
  logic        id_ex_we;
  logic        id_ex_flush;
  logic        ex_mem_we;
  logic        ex_mem_flush;
  logic        mul_busy;
  logic [31:0] stall_cycles;
  logic [6:0]  w_out;

  int unsigned checks;
  int unsigned errors;

  // Output vector: {pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_flush, ex_mem_we, ex_mem_flush}
  localparam logic [6:0] NORMAL = 7'b1101010;
  localparam logic [6:0] LDUSE  = 7'b0001110;
  localparam logic [6:0] MULFRZ = 7'b0000011;
  localparam logic [6:0] BRANCH = 7'b1111110;
  localparam logic [6:0] MEMSTL = 7'b0000000;

  pipeline_hazard_ctrl #(
    .MUL_LAT (4),
    .CNT_W   (32)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .id_rgS1_index (id_rgS1_index),
    .id_rgS2_index (id_rgS2_index),
    .id_use_s1     (id_use_s1),
    .id_use_s2     (id_use_s2),
    .ex_control    (ex_control),
    .ex_rgD_index  (ex_rgD_index),
    .ex_br_taken   (ex_br_taken),
    .mem_stall     (mem_stall),
    .pc_we         (pc_we),
    .if_id_we      (if_id_we),
    .if_id_flush   (if_id_flush),
    .id_ex_we      (id_ex_we),
    .id_ex_flush   (id_ex_flush),
    .ex_mem_we     (ex_mem_we),
    .ex_mem_flush  (ex_mem_flush),
    .mul_busy      (mul_busy),
    .stall_cycles  (stall_cycles)
  );

  assign w_out = {pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_flush, ex_mem_we, ex_mem_flush};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_idle();
    id_rgS1_index = '0;
    id_rgS2_index = '0;
    id_use_s1     = 1'b0;
    id_use_s2     = 1'b0;
    ex_control    = '0;
    ex_rgD_index  = '0;
    ex_br_taken   = 1'b0;
    mem_stall     = 1'b0;
  endtask

  // Inputs change on negedge; checks happen 1 time unit later.
  task automatic next_cycle();
    @(negedge clk);
    set_idle();
  endtask

  task automatic apply_reset();
    @(negedge clk);
    set_idle();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    set_idle();
    reset = 1'b1;
    ex_control[6] = 1'b1;
    mem_stall = 1'b1;
    #1;
    checks++;
    if (w_out !== NORMAL) begin
      errors++;
      $display("FAIL reset_forced_outputs: got %b expected %b", w_out, NORMAL);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    set_idle();
    reset = 1'b0;
    #1;
    checks++;
    if (w_out !== NORMAL) begin
      errors++;
      $display("FAIL reset_release_outputs: got %b expected %b", w_out, NORMAL);
    end
    checks++;
    if (stall_cycles !== 32'd0) begin
      errors++;
      $display("FAIL reset_stall_cycles: got %0d expected 0", stall_cycles);
    end
    checks++;
    if (mul_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mul_busy: got %b expected 0", mul_busy);
    end
  endtask

  task automatic test_load_use();
    apply_reset();
    ex_control[5] = 1'b1;
    ex_rgD_index  = 5'd7;
    id_use_s2     = 1'b1;
    id_rgS2_index = 5'd7;
    #1;
    checks++;
    if (w_out !== LDUSE) begin
      errors++;
      $display("FAIL load_use_s2: got %b expected %b", w_out, LDUSE);
    end
    next_cycle();
    #1;
    checks++;
    if (w_out !== NORMAL) begin
      errors++;
      $display("FAIL load_use_after: got %b expected %b", w_out, NORMAL);
    end
    checks++;
    if (stall_cycles !== 32'd1) begin
      errors++;
      $display("FAIL load_use_count: got %0d expected 1", stall_cycles);
    end
    // r0 destination never interlocks
    ex_control[5] = 1'b1;
    ex_rgD_index  = 5'd0;
    id_use_s2     = 1'b1;
    id_rgS2_index = 5'd0;
    #1;
    checks++;
    if (w_out !== NORMAL) begin
      errors++;
      $display("FAIL load_use_r0: got %b expected %b", w_out, NORMAL);
    end
    // index match on a source that is not read
    next_cycle();
    ex_control[5] = 1'b1;
    ex_rgD_index  = 5'd9;
    id_use_s1     = 1'b0;
    id_rgS1_index = 5'd9;
    #1;
    checks++;
    if (w_out !== NORMAL) begin
      errors++;
      $display("FAIL load_use_unused_src: got %b expected %b", w_out, NORMAL);
    end
    // source 1 match, read
    next_cycle();
    ex_control[5] = 1'b1;
    ex_rgD_index  = 5'd31;
    id_use_s1     = 1'b1;
    id_rgS1_index = 5'd31;
    #1;
    checks++;
    if (w_out !== LDUSE) begin
      errors++;
      $display("FAIL load_use_s1: got %b expected %b", w_out, LDUSE);
    end
    next_cycle();
    #1;
    checks++;
    if (stall_cycles !== 32'd2) begin
      errors++;
      $display("FAIL load_use_count2: got %0d expected 2", stall_cycles);
    end
  endtask

  task automatic test_mul();
    logic [6:0] exp_out [0:3];
    logic       exp_busy [0:3];
    exp_out[0] = MULFRZ; exp_busy[0] = 1'b0;
    exp_out[1] = MULFRZ; exp_busy[1] = 1'b1;
    exp_out[2] = MULFRZ; exp_busy[2] = 1'b1;
    exp_out[3] = NORMAL; exp_busy[3] = 1'b1;
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      if (i != 0) next_cycle();
      ex_control[6] = 1'b1;
      #1;
      checks++;
      if (w_out !== exp_out[i]) begin
        errors++;
        $display("FAIL mul_cycle%0d_out: got %b expected %b", i, w_out, exp_out[i]);
      end
      checks++;
      if (mul_busy !== exp_busy[i]) begin
        errors++;
        $display("FAIL mul_cycle%0d_busy: got %b expected %b", i, mul_busy, exp_busy[i]);
      end
    end
    next_cycle();
    #1;
    checks++;
    if (mul_busy !== 1'b0) begin
      errors++;
      $display("FAIL mul_done_busy: got %b expected 0", mul_busy);
    end
    checks++;
    if (stall_cycles !== 32'd3) begin
      errors++;
      $display("FAIL mul_count: got %0d expected 3", stall_cycles);
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      if (i != 0) next_cycle();
      ex_control[6] = 1'b1;
      #1;
      // cycle 4 is the second mul's start cycle
      if (i == 4) begin
        checks++;
        if (w_out !== MULFRZ || mul_busy !== 1'b0) begin
          errors++;
          $display("FAIL b2b_retrigger: got %b busy %b expected %b busy 0", w_out, mul_busy, MULFRZ);
        end
      end
      if (i == 7) begin
        checks++;
        if (w_out !== NORMAL) begin
          errors++;
          $display("FAIL b2b_release: got %b expected %b", w_out, NORMAL);
        end
      end
    end
    next_cycle();
    #1;
    checks++;
    if (stall_cycles !== 32'd6) begin
      errors++;
      $display("FAIL b2b_count: got %0d expected 6", stall_cycles);
    end
  endtask

  task automatic test_branch_loaduse();
    apply_reset();
    ex_control[5] = 1'b1;
    ex_rgD_index  = 5'd4;
    id_use_s1     = 1'b1;
    id_rgS1_index = 5'd4;
    ex_br_taken   = 1'b1;
    #1;
    checks++;
    if (w_out !== BRANCH) begin
      errors++;
      $display("FAIL branch_over_loaduse: got %b expected %b", w_out, BRANCH);
    end
    next_cycle();
    #1;
    checks++;
    if (stall_cycles !== 32'd0) begin
      errors++;
      $display("FAIL branch_count: got %0d expected 0", stall_cycles);
    end
  endtask

  task automatic test_mem_stall_mul();
    apply_reset();
    ex_control[6] = 1'b1;                    // cycle0: start, cnt->2
    next_cycle(); ex_control[6] = 1'b1;      // cycle1: cnt 2->1
    for (int i = 0; i < 2; i++) begin        // cycles 2,3: memory freeze
      next_cycle();
      ex_control[6] = 1'b1;
      mem_stall = 1'b1;
      #1;
      checks++;
      if (w_out !== MEMSTL) begin
        errors++;
        $display("FAIL memstall_cycle%0d: got %b expected %b", i, w_out, MEMSTL);
      end
    end
    next_cycle(); ex_control[6] = 1'b1;      // cycle4: cnt still 1 -> frozen
    #1;
    checks++;
    if (w_out !== MULFRZ) begin
      errors++;
      $display("FAIL memstall_resume_freeze: got %b expected %b", w_out, MULFRZ);
    end
    next_cycle(); ex_control[6] = 1'b1;      // cycle5: release
    #1;
    checks++;
    if (w_out !== NORMAL || mul_busy !== 1'b1) begin
      errors++;
      $display("FAIL memstall_release: got %b busy %b expected %b busy 1", w_out, mul_busy, NORMAL);
    end
    next_cycle();
    #1;
    checks++;
    if (stall_cycles !== 32'd5 || mul_busy !== 1'b0) begin
      errors++;
      $display("FAIL memstall_count: got %0d busy %b expected 5 busy 0", stall_cycles, mul_busy);
    end
  endtask

  task automatic test_reset_mid_mul();
    apply_reset();
    ex_control[6] = 1'b1;
    next_cycle(); ex_control[6] = 1'b1;
    #1;
    checks++;
    if (mul_busy !== 1'b1) begin
      errors++;
      $display("FAIL midreset_busy_before: got %b expected 1", mul_busy);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (w_out !== NORMAL) begin
      errors++;
      $display("FAIL midreset_forced: got %b expected %b", w_out, NORMAL);
    end
    next_cycle();
    reset = 1'b0;
    #1;
    checks++;
    if (mul_busy !== 1'b0 || stall_cycles !== 32'd0 || w_out !== NORMAL) begin
      errors++;
      $display("FAIL midreset_after: busy %b count %0d out %b expected 0 0 %b",
               mul_busy, stall_cycles, w_out, NORMAL);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    set_idle();
    test_reset();
    test_load_use();
    test_mul();
    test_back_to_back();
    test_branch_loaduse();
    test_mem_stall_mul();
    test_reset_mid_mul();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
